// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU engine.
// Walks a single 1-bit ALU slice LSB-first over WIDTH clocks, with a carry
// flip-flop between cycles. It returns the full-width result, carry-out and
// zero flag together with a one-cycle done pulse.
module alu_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0]    OP_AND   = 2'b00;
    localparam logic [1:0]    OP_OR    = 2'b01;
    localparam logic [1:0]    OP_ADD   = 2'b10;
    localparam logic [1:0]    OP_SUB   = 2'b11;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [1:0]       op;

    // Slice signals
    logic             r_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] sr_nxt;
    logic             accept;
    logic             last;

    // Requests are taken in IDLE and also in DONE, which is what allows back-to-back ops
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST_BIT);

    // One-bit ALU slice plus the result shift-in value
    always_comb begin
        c_nxt = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        case (op)
            OP_AND:  r_bit = sa[0] & sb[0];
            OP_OR:   r_bit = sa[0] | sb[0];
            default: r_bit = sa[0] ^ sb[0] ^ carry;
        endcase
        sr_nxt = {r_bit, sr[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture, serial datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            op    <= OP_AND;
            y     <= '0;
            cout  <= 1'b0;
            zero  <= 1'b1;
        end else if (accept) begin
            // SUB is done as A + ~B + 1, so B is inverted at capture and the carry is preset
            sa  <= a;
            sb  <= (s == OP_SUB) ? ~b : b;
            op  <= s;
            cnt <= '0;
            sr  <= '0;
            case (s)
                OP_ADD:  carry <= cin;
                OP_SUB:  carry <= 1'b1;
                default: carry <= 1'b0;
            endcase
        end else if (state == RUN) begin
            sr  <= sr_nxt;
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + CW'(1);
            if (op[1]) begin
                carry <= c_nxt;
            end
            if (last) begin
                y    <= sr_nxt;
                cout <= op[1] ? c_nxt : 1'b0;
                zero <= (sr_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Testbench for alu_serial_ctrl: scoreboard of expected results pushed at
// request time and popped when done is observed.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   s;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         cout;
    logic         zero;

    typedef struct {
        logic [W-1:0] y;
        logic         cout;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_serial_ctrl #(.WIDTH(W), .CW(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .cout  (cout),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: compute the expected result and push it to the scoreboard
    task automatic push_expected(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic [1:0] ts, input logic tc);
        exp_t e;
        logic [W:0] sum;
        case (ts)
            2'b00: begin e.y = ta & tb_; e.cout = 1'b0; end
            2'b01: begin e.y = ta | tb_; e.cout = 1'b0; end
            2'b10: begin
                sum = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
                e.y = sum[W-1:0]; e.cout = sum[W];
            end
            default: begin
                sum = {1'b0, ta} + {1'b0, ~tb_} + {{W{1'b0}}, 1'b1};
                e.y = sum[W-1:0]; e.cout = sum[W];
            end
        endcase
        e.zero = (e.y == '0);
        exp_q.push_back(e);
    endtask

    // Scoreboard checker: every done pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: y=%h with empty scoreboard", y);
            end else begin
                e = exp_q.pop_front();
                if (y !== e.y || cout !== e.cout || zero !== e.zero) begin
                    errors++;
                    $display("FAIL sb_result: got y=%h cout=%b zero=%b, expected y=%h cout=%b zero=%b",
                             y, cout, zero, e.y, e.cout, e.zero);
                end
            end
        end
    end

    // Issue one op and check latency, busy length and output stability while busy.
    // With poke set, start is toggled with zero operands during RUN; that must be ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [1:0] ts, input logic tc, input bit poke);
        int n;
        int busy_cnt;
        logic [W-1:0] yhold;
        bit ystable;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; s = ts; cin = tc;
        push_expected(ta, tb_, ts, tc);
        yhold = y;
        ystable = 1'b1;
        busy_cnt = 0;
        @(negedge clk);
        n = 1;
        start = 1'b0;
        while (!done && n <= W + 5) begin
            if (busy) busy_cnt++;
            if (y !== yhold) ystable = 1'b0;
            if (poke && n >= 3 && n <= 20) begin
                start = n[0]; a = '0; b = '0; s = 2'b00; cin = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++;
        if (n !== W + 1) begin
            errors++;
            $display("FAIL latency: done at cycle %0d, expected %0d", n, W + 1);
        end
        checks++;
        if (busy_cnt !== W) begin
            errors++;
            $display("FAIL busy_len: busy for %0d cycles, expected %0d", busy_cnt, W);
        end
        checks++;
        if (ystable !== 1'b1) begin
            errors++;
            $display("FAIL y_stable: y changed while busy (held %h)", yhold);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; s = 2'b00; cin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (y !== '0 || cout !== 1'b0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: y=%h cout=%b zero=%b busy=%b done=%b, expected 0/0/1/0/0",
                     y, cout, zero, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h0FED_CBA9, 2'b10, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_op(32'd5, 32'd7, 2'b11, 1'b1, 1'b0);
        run_op(32'd7, 32'd5, 2'b11, 1'b0, 1'b0);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic test_logic();
        run_op(32'hF0F0_A5A5, 32'h0FF0_FFFF, 2'b00, 1'b1, 1'b0);
        run_op(32'hF0F0_A5A5, 32'h0FF0_FFFF, 2'b01, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op(32'h7FFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 1'b1);
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; a = 32'h0000_1111; b = 32'h0000_2222; s = 2'b10; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== '0 || zero !== 1'b1 || cout !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b y=%h zero=%b cout=%b, expected 0/0/0/1/0",
                     busy, done, y, zero, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h0000_00FF, 32'h0000_0F00, 2'b01, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; s = 2'b10; cin = 1'b1;
        push_expected(a, b, s, cin);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < W + 5);
        checks++;
        if (n !== W + 1) begin
            errors++;
            $display("FAIL b2b_first_latency: done at cycle %0d, expected %0d", n, W + 1);
        end
        a = 32'h0000_0003; b = 32'h0000_0009; s = 2'b11; cin = 1'b0;
        push_expected(a, b, s, cin);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%b after DONE with start held, expected 1", busy);
        end
        while (!done && n < W + 5) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== W + 1) begin
            errors++;
            $display("FAIL b2b_second_latency: done at cycle %0d, expected %0d", n, W + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results never produced, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
